// File: rtl/replay_recorder_if.sv
// Bus between the frame source/renderer and the replay recorder.
// Carries live coordinates in, replay controls in, and playback/status out.
interface replay_recorder_if #(
  parameter int N_CH    = 3,
  parameter int COORD_W = 10,
  parameter int DEPTH   = 512
);
  localparam int AW     = $clog2(DEPTH);
  localparam int SLOT_W = 2*N_CH*COORD_W;

  logic              frame_tick;
  logic [SLOT_W-1:0] live_pos;
  logic              trigger;
  logic              abort;
  logic [AW-1:0]     replay_len;
  logic [2:0]        slow_factor;
  logic [SLOT_W-1:0] out_pos;
  logic              replaying;
  logic              done;
  logic [AW:0]       fill_count;

  modport master (
    output frame_tick, live_pos, trigger, abort, replay_len, slow_factor,
    input  out_pos, replaying, done, fill_count
  );

  modport slave (
    input  frame_tick, live_pos, trigger, abort, replay_len, slow_factor,
    output out_pos, replaying, done, fill_count
  );
endinterface

// File: rtl/replay_recorder.sv
// Circular frame history of object coordinates with triggered, optionally
// slowed-down instant replay of the most recent frames.
module replay_recorder #(
  parameter int N_CH    = 3,
  parameter int COORD_W = 10,
  parameter int DEPTH   = 512
) (
  input logic                clk,
  input logic                reset_n,
  replay_recorder_if.slave   bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int SLOT_W = 2*N_CH*COORD_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  typedef enum logic {RECORD, REPLAY} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [AW:0]       rem_q, rem_d;
  logic              pend_q, pend_d;
  logic [2:0]        slow_cnt_q, slow_cnt_d;
  logic [2:0]        slow_q, slow_d;
  logic              done_q, done_d;
  logic              we;
  logic [AW:0]       fill_inc, len_req, len;
  logic [SLOT_W-1:0] mem [DEPTH];
  logic [SLOT_W-1:0] rd_data;
  logic [SLOT_W-1:0] out_pos_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    rem_d      = rem_q;
    pend_d     = pend_q;
    slow_cnt_d = slow_cnt_q;
    slow_d     = slow_q;
    done_d     = 1'b0;
    we         = 1'b0;
    fill_inc   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    len_req    = (bus.replay_len == '0) ? ONE : {1'b0, bus.replay_len};
    len        = (len_req < fill_inc) ? len_req : fill_inc;
    case (state_q)
      RECORD: begin
        if (bus.trigger && !bus.abort) pend_d = 1'b1;
        if (bus.frame_tick) begin
          we       = reset_n;
          wr_ptr_d = wr_ptr_q + 1'b1;
          fill_d   = fill_inc;
          // fill_inc is never zero after a write, so a pending trigger always starts
          if (pend_q) begin
            pend_d     = 1'b0;
            state_d    = REPLAY;
            rd_ptr_d   = wr_ptr_d - len[AW-1:0];
            rem_d      = len;
            slow_cnt_d = '0;
            slow_d     = bus.slow_factor;
          end
        end
      end
      REPLAY: begin
        if (bus.abort) begin
          state_d = RECORD;
        end else if (bus.frame_tick) begin
          if (slow_cnt_q != slow_q) begin
            slow_cnt_d = slow_cnt_q + 1'b1;
          end else begin
            slow_cnt_d = '0;
            if (rem_q == ONE) begin
              state_d = RECORD;
              done_d  = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
              rem_d    = rem_q - 1'b1;
            end
          end
        end
      end
      default: state_d = RECORD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RECORD;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      rem_q      <= '0;
      pend_q     <= 1'b0;
      slow_cnt_q <= '0;
      slow_q     <= '0;
      done_q     <= 1'b0;
      out_pos_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      rem_q      <= rem_d;
      pend_q     <= pend_d;
      slow_cnt_q <= slow_cnt_d;
      slow_q     <= slow_d;
      done_q     <= done_d;
      // first REPLAY cycle shows a stale read; valid two cycles after rd_ptr moves
      out_pos_q  <= (state_q == REPLAY) ? rd_data : bus.live_pos;
    end
  end

  // Plain one-write/one-read RAM, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= bus.live_pos;
    rd_data <= mem[rd_ptr_q];
  end

  assign bus.out_pos    = out_pos_q;
  assign bus.replaying  = (state_q == REPLAY);
  assign bus.done       = done_q;
  assign bus.fill_count = fill_q;
endmodule

// File: tb/tb_replay_recorder.sv
// Bench for replay_recorder: directed table of replay scenarios, hand-written
// corner sequences, and random traffic against a frame-list reference model.
module tb_replay_recorder;
  localparam int DEPTH = 16;
  localparam int SW    = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  replay_recorder_if #(.N_CH(1), .COORD_W(10), .DEPTH(DEPTH)) bus();

  replay_recorder #(.N_CH(1), .COORD_W(10), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    int n; int base; int rlen; int slow; int fill; int first; int cnt;
  } vec_t;
  vec_t tbl[6];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_q[$];

  // reference model: recorded frames and the expanded list of ticks to show
  logic [SW-1:0] hist[$];
  logic [SW-1:0] play[$];
  bit            m_rep = 0, m_pend = 0, m_done = 0, m_out_ok = 0;
  logic [SW-1:0] m_out = '0;
  int            since = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int rl, L;
    bit start;
    m_done = 0;
    m_out_ok = 0;
    if (!reset_n) begin
      hist.delete(); play.delete();
      m_rep = 0; m_pend = 0; m_out_ok = 1; m_out = '0;
      return;
    end
    since++;
    if (!m_rep) begin m_out_ok = 1; m_out = bus.live_pos; end
    else if (since >= 2) begin m_out_ok = 1; m_out = play[0]; end
    if (!m_rep) begin
      start = bus.frame_tick && m_pend;
      if (bus.frame_tick) begin
        hist.push_back(bus.live_pos);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      if (bus.trigger && !bus.abort) m_pend = 1;
      if (start) begin
        m_pend = 0;
        rl = (bus.replay_len == 0) ? 1 : int'(bus.replay_len);
        L = (rl < hist.size()) ? rl : hist.size();
        play.delete();
        for (int i = hist.size() - L; i < hist.size(); i++)
          repeat (int'(bus.slow_factor) + 1) play.push_back(hist[i]);
        m_rep = 1;
        since = 0;
      end
    end else if (bus.abort) begin
      m_rep = 0;
      play.delete();
    end else if (bus.frame_tick) begin
      void'(play.pop_front());
      since = 0;
      if (play.size() == 0) begin m_rep = 0; m_done = 1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("replaying", int'(bus.replaying), int'(m_rep));
    chk("done", int'(bus.done), int'(m_done));
    chk("fill_count", int'(bus.fill_count), hist.size());
    if (m_out_ok) chk("out_pos", int'(bus.out_pos), int'(m_out));
    if (bus.done) done_cnt++;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cycle();
    bus.frame_tick = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic record(input int v, input bit trig);
    bus.live_pos = SW'(v);
    if (trig) begin
      bus.trigger = 1'b1;
      cycle();
      bus.trigger = 1'b0;
    end
    tick();
  endtask

  task automatic do_reset();
    bus.frame_tick = 1'b0; bus.trigger = 1'b0; bus.abort = 1'b0;
    reset_n = 1'b0;
    repeat (2) cycle();
    chk("rst_out_pos", int'(bus.out_pos), 0);
    chk("rst_replaying", int'(bus.replaying), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_fill", int'(bus.fill_count), 0);
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic expect_replay(input int slow);
    done_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++)
      for (int h = 0; h <= slow; h++) begin
        chk("rp_active", int'(bus.replaying), 1);
        chk("rp_sample", int'(bus.out_pos), exp_q[i]);
        tick();
      end
    chk("rp_done_once", done_cnt, 1);
    chk("rp_ended", int'(bus.replaying), 0);
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.trigger = 1'b0; bus.abort = 1'b0;
    bus.live_pos = '0; bus.replay_len = '0; bus.slow_factor = '0;
    tbl[0] = '{20,   0,  5, 0, 16,  15,  5};
    tbl[1] = '{ 3,   0, 10, 0,  3,   0,  3};
    tbl[2] = '{10,   0,  2, 3, 10,   8,  2};
    tbl[3] = '{16, 100,  0, 1, 16, 115,  1};
    tbl[4] = '{16, 200, 15, 0, 16, 201, 15};
    tbl[5] = '{ 1,   7,  3, 2,  1,   7,  1};

    for (int t = 0; t < 6; t++) begin
      do_reset();
      bus.replay_len  = 4'(tbl[t].rlen);
      bus.slow_factor = 3'(tbl[t].slow);
      for (int k = 0; k < tbl[t].n; k++) record(tbl[t].base + k, k == tbl[t].n - 1);
      chk("tbl_fill", int'(bus.fill_count), tbl[t].fill);
      exp_q.delete();
      for (int s = 0; s < tbl[t].cnt; s++) exp_q.push_back(tbl[t].first + s);
      expect_replay(tbl[t].slow);
    end

    // abort after the second sample, with a stray trigger during the replay
    do_reset();
    bus.replay_len = 4'd5; bus.slow_factor = 3'd0;
    for (int k = 0; k < 8; k++) record(50 + k, k == 7);
    chk("ab_first", int'(bus.out_pos), 53);
    tick();
    chk("ab_second", int'(bus.out_pos), 54);
    bus.trigger = 1'b1; cycle(); bus.trigger = 1'b0; cycle();
    done_cnt = 0;
    bus.abort = 1'b1; cycle(); bus.abort = 1'b0;
    chk("ab_state", int'(bus.replaying), 0);
    repeat (3) cycle();
    chk("ab_no_done", done_cnt, 0);
    record(98, 0);
    chk("ab_no_second", int'(bus.replaying), 0);
    chk("ab_fill", int'(bus.fill_count), 9);
    bus.replay_len = 4'd3;
    record(99, 1);
    exp_q = '{57, 98, 99};
    expect_replay(0);

    // reset in the middle of a replay, then a one-frame replay
    bus.replay_len = 4'd4;
    record(500, 1);
    chk("mr_active", int'(bus.replaying), 1);
    tick();
    done_cnt = 0;
    reset_n = 1'b0; cycle();
    chk("mr_out", int'(bus.out_pos), 0);
    chk("mr_fill", int'(bus.fill_count), 0);
    chk("mr_repl", int'(bus.replaying), 0);
    reset_n = 1'b1; cycle();
    chk("mr_no_done", done_cnt, 0);
    bus.replay_len = 4'd5;
    record(333, 1);
    exp_q = '{333};
    expect_replay(0);

    // trigger and abort together in RECORD
    do_reset();
    record(1, 0); record(2, 0);
    bus.trigger = 1'b1; bus.abort = 1'b1; cycle();
    bus.trigger = 1'b0; bus.abort = 1'b0;
    tick();
    chk("collision", int'(bus.replaying), 0);

    // random traffic, all checked by the model inside cycle()
    for (int c = 0; c < 4000; c++) begin
      bus.frame_tick  = ($urandom_range(2) == 0);
      bus.trigger     = ($urandom_range(15) == 0);
      bus.abort       = ($urandom_range(59) == 0);
      bus.replay_len  = 4'($urandom_range(15));
      bus.slow_factor = 3'($urandom_range(3));
      bus.live_pos    = SW'($urandom);
      reset_n         = ($urandom_range(999) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/replay_recorder.md
REPLAY_RECORDER -- requirements
Module: replay_recorder

Interface
REQ-001 Parameter N_CH, default 3, number of tracked objects; each object carries an (x,y) pair.
REQ-002 Parameter COORD_W, default 10, width of each coordinate.
REQ-003 Parameter DEPTH, default 512, history depth in frames; SHALL be a power of two, with AW = log2(DEPTH).
REQ-004 Derived widths: SLOT_W = 2*N_CH*COORD_W; fill_count width is AW+1.
REQ-005 clk  in  1  system clock.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 live_pos  in  SLOT_W  live coordinates of all objects, object 0 in the LSBs.
REQ-009 trigger  in  1  replay request, one-cycle pulse, accepted on any cycle.
REQ-010 abort  in  1  level; cancels a replay in progress.
REQ-011 replay_len  in  AW  requested number of frames to replay.
REQ-012 slow_factor  in  3  playback hold; each recorded frame is shown for slow_factor+1 ticks.
REQ-013 out_pos  out  SLOT_W  registered coordinates for the renderer.
REQ-014 replaying  out  1  high while in the REPLAY state.
REQ-015 done  out  1  one-cycle pulse when a replay completes normally.
REQ-016 fill_count  out  AW+1  number of valid history frames, saturating at DEPTH.

Function
REQ-017 Two states SHALL exist: RECORD (after reset) and REPLAY.
REQ-018 Writes in RECORD:
- On each frame_tick, write live_pos to mem[wr_ptr].
- Increment wr_ptr modulo DEPTH, so it wraps from DEPTH-1 to 0.
- Increment fill_count, saturating at DEPTH.
REQ-019 In REPLAY, no writes SHALL occur; wr_ptr and fill_count SHALL be held.
REQ-020 Trigger latching in RECORD:
- A trigger in RECORD sets a pending flag.
- The flag is consumed at the next frame_tick.
- Triggers received while in REPLAY SHALL be discarded and not latched.
REQ-021 Replay start: on a frame_tick with the pending flag set and fill_count after that tick's write greater than 0:
- L = min(replay_len, fill_count), with replay_len=0 treated as 1.
- rd_ptr = (wr_ptr_new - L) mod DEPTH.
- remaining = L; slow_cnt = 0; state goes to REPLAY.
- The pending flag is cleared.
REQ-022 Playback advance: on each frame_tick in REPLAY:
- If slow_cnt != slow_factor, slow_cnt increments.
- Otherwise slow_cnt clears, and then:
  - if remaining == 1, state goes to RECORD and done pulses on the following cycle;
  - else rd_ptr increments modulo DEPTH and remaining decrements.
REQ-023 Sample order: replay SHALL present exactly L samples, oldest first, ending with the frame written on the trigger tick.
REQ-024 Memory and output timing:
- The memory read is synchronous with 1-cycle latency.
- out_pos SHALL equal mem[rd_ptr] two cycles after any rd_ptr change while in REPLAY.
- In RECORD, out_pos SHALL equal live_pos delayed by one cycle.
REQ-025 Abort:
- abort high in REPLAY returns the state to RECORD on the next cycle.
- No done pulse is generated; recording resumes at the unchanged wr_ptr.
REQ-026 abort and trigger in the same RECORD cycle: abort wins, and the trigger is not latched.
REQ-027 slow_factor and replay_len SHALL be sampled only at replay start; later changes do not affect the replay in progress.
REQ-028 A frame_tick is never dropped: a replay completion and a pending start can never coincide, because triggers are discarded during REPLAY.
REQ-029 The memory SHALL be inferable as block RAM: one write port and one synchronous read port.

Reset
REQ-030 Reset values when reset_n is low at a clk edge:
- state RECORD, wr_ptr=0, rd_ptr=0, fill_count=0.
- pending=0, slow_cnt=0, remaining=0.
- out_pos=0, replaying=0, done=0.
REQ-031 Memory contents SHALL NOT be cleared by reset; fill_count=0 guarantees they are never replayed.
REQ-032 Reset asserted mid-replay SHALL abandon the replay immediately, with no done pulse.

Verification (DEPTH=16, N_CH=1, COORD_W=10)
REQ-033 Wrap replay: record 20 frames with live_pos = k (k = 0..19), then trigger with replay_len=5 and slow_factor=0.
- Expected: fill_count=16; out_pos shows 15,16,17,18,19, one frame each.
- done pulses once; replaying stays high for 5 frame_ticks.
REQ-034 Clamp: after reset, record 3 frames, trigger with replay_len=10.
- Expected: L=3; samples are 0,1,2; then done.
REQ-035 Slow motion: slow_factor=3 and replay_len=2 over history ...,8,9.
- Expected: out_pos=8 for 4 ticks, then 9 for 4 ticks; done after the 8th tick.
REQ-036 Abort: abort after the 2nd sample of a 5-frame replay.
- Expected: RECORD on the next cycle; no done pulse; the next write lands at the previous wr_ptr.
- A trigger sent during the replay produced no second replay.
REQ-037 Reset mid-replay: assert reset_n=0 during REPLAY.
- Expected: all outputs 0 and fill_count=0.
- A trigger with no subsequent frames still replays only the frame written on the trigger tick: L=1.
REQ-038 Collision: assert trigger and abort in the same RECORD cycle.
- Expected: no replay at the next frame_tick.
